// File: rtl/pla_sweep_misr.sv
// Exhaustive PLA input sweep with MISR compaction of the responses.
// Drives x = 0..2^NUM_IN-1, absorbs z after SETTLE extra cycles, pulses done with the signature.
module pla_sweep_misr #(
  parameter int unsigned       NUM_IN  = 7,
  parameter int unsigned       NUM_OUT = 10,
  parameter int unsigned       SIG_W   = 16,
  parameter logic [SIG_W-1:0]  POLY    = 16'h1021,
  parameter logic [SIG_W-1:0]  SEED    = 16'h0000,
  parameter int unsigned       SETTLE  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  output logic [NUM_IN-1:0]  x,
  input  logic [NUM_OUT-1:0] z,
  output logic               busy,
  output logic               done,
  output logic [SIG_W-1:0]   signature
);

  localparam logic [NUM_IN-1:0] XLast     = '1;
  localparam logic [3:0]        SettleCnt = 4'(SETTLE);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [NUM_IN-1:0] x_q, x_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic              done_q, done_d;
  logic [SIG_W-1:0]  misr_next;

  // One MISR step: shift, conditional polynomial feedback, fold in zero-extended z.
  always_comb begin
    misr_next = {sig_q[SIG_W-2:0], 1'b0};
    if (sig_q[SIG_W-1]) begin
      misr_next = misr_next ^ POLY;
    end
    misr_next = misr_next ^ SIG_W'(z);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          x_d     = '0;
          cnt_d   = '0;
          sig_d   = SEED;
        end
      end
      StRun: begin
        // Pause freezes everything, including a final absorb.
        if (!pause) begin
          if (cnt_q < SettleCnt) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            sig_d = misr_next;
            cnt_d = '0;
            if (x_q == XLast) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      cnt_q   <= '0;
      sig_q   <= SEED;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      done_q  <= done_d;
    end
  end

  assign x         = x_q;
  assign busy      = (state_q == StRun);
  assign done      = done_q;
  assign signature = sig_q;

endmodule
